// File: rtl/pipe_hazard_pkg.sv
// Shared types for the hazard controller: tracker entry layout, forward-select encoding, source match.
// Register fields are stored at RA_MAX bits so any REG_AW up to 8 fits without re-typing the struct.
package pipe_hazard_pkg;

  localparam int RA_MAX      = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic              valid;
    logic [RA_MAX-1:0] rd;
    logic              regwrite;
    logic              is_load;
    logic [RA_MAX-1:0] rs;
    logic [RA_MAX-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } trk_entry_t;

  // Register 0 is hard-wired, so a write to it can never satisfy a reader.
  function automatic logic src_match(trk_entry_t e, logic [RA_MAX-1:0] addr, logic use_src);
    return e.valid && e.regwrite && use_src && (e.rd == addr) && (e.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones, frozen while hold is high.
// One-cycle update latency; synchronous active-high reset.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (!hold && inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller over DEPTH post-decode stages: ID stall/bubble, IF/ID flush, EX forward selects.
// Outputs combinational, tracker shifts in 1 cycle; define BRANCH_ID_RESOLVE_EN for ID-stage branch operand stalls.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 3,
  parameter int LOAD_FWD_IDX = 2,
  parameter int CNT_W        = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     hold_i,
  input  logic                     id_valid_i,
  input  logic [REG_AW-1:0]        id_rs_i,
  input  logic [REG_AW-1:0]        id_rt_i,
  input  logic                     id_use_rs_i,
  input  logic                     id_use_rt_i,
  input  logic [REG_AW-1:0]        id_rd_i,
  input  logic                     id_regwrite_i,
  input  logic                     id_is_load_i,
  input  logic                     id_branch_i,
  input  logic                     id_branch_taken_i,
  input  logic                     id_jump_i,
  output logic                     stall_o,
  output logic                     flush_o,
  output logic [$clog2(DEPTH)-1:0] fwd_rs_sel_o,
  output logic [$clog2(DEPTH)-1:0] fwd_rt_sel_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         flush_cnt_o
);

  localparam int SW = $clog2(DEPTH);

  trk_entry_t [DEPTH-1:0] trk;
  trk_entry_t             id_ent;
  trk_entry_t             ent0_nxt;
  logic                   load_use;
  logic                   br_haz;
  logic                   hazard;
  logic                   unused_retire;

  always_comb begin
    id_ent          = '0;
    id_ent.valid    = id_valid_i;
    id_ent.rd       = RA_MAX'(id_rd_i);
    id_ent.regwrite = id_regwrite_i;
    id_ent.is_load  = id_is_load_i;
    id_ent.rs       = RA_MAX'(id_rs_i);
    id_ent.rt       = RA_MAX'(id_rt_i);
    id_ent.use_rs   = id_use_rs_i;
    id_ent.use_rt   = id_use_rt_i;
  end

  always_comb begin
    load_use = 1'b0;
    br_haz   = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (trk[j].is_load && ((j + 1) < LOAD_FWD_IDX) &&
          (src_match(trk[j], id_ent.rs, id_use_rs_i) || src_match(trk[j], id_ent.rt, id_use_rt_i))) begin
        load_use = 1'b1;
      end
`ifdef BRANCH_ID_RESOLVE_EN
      // The last entry writes the regfile this cycle and is covered by write-through.
      if (id_branch_i && (j < DEPTH - 1) &&
          (src_match(trk[j], id_ent.rs, id_use_rs_i) || src_match(trk[j], id_ent.rt, id_use_rt_i))) begin
        br_haz = 1'b1;
      end
`endif
    end
  end

  assign hazard  = !rst_i && id_valid_i && (load_use || br_haz);
  assign stall_o = !rst_i && (hazard || hold_i);
  assign flush_o = !rst_i && id_valid_i && !stall_o && (id_jump_i || (id_branch_i && id_branch_taken_i));

  // Scan oldest to youngest so the youngest matching writer is the one left standing.
  always_comb begin
    fwd_rs_sel_o = SW'(FWD_REGFILE);
    fwd_rt_sel_o = SW'(FWD_REGFILE);
    if (!rst_i && trk[0].valid) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (src_match(trk[k], trk[0].rs, trk[0].use_rs)) fwd_rs_sel_o = SW'(k);
        if (src_match(trk[k], trk[0].rt, trk[0].use_rt)) fwd_rt_sel_o = SW'(k);
      end
    end
  end

  assign ent0_nxt = stall_o ? trk_entry_t'('0) : id_ent;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trk <= '0;
    end else if (!hold_i) begin
      trk <= {trk[DEPTH-2:0], ent0_nxt};
    end
  end

  assign unused_retire = ^{trk[DEPTH-1].rs, trk[DEPTH-1].rt, trk[DEPTH-1].use_rs, trk[DEPTH-1].use_rt};

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .hold  (hold_i),
    .inc   (hazard),
    .count (stall_cnt_o)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .hold  (hold_i),
    .inc   (flush_o),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic against an in-flight instruction queue model.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int DEPTH   = 3;
  localparam int LFI     = 2;
  localparam int CNT_W   = 2;
  localparam int SW      = $clog2(DEPTH);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_i, hold_i, id_valid_i;
  logic [REG_AW-1:0] id_rs_i, id_rt_i, id_rd_i;
  logic              id_use_rs_i, id_use_rt_i, id_regwrite_i, id_is_load_i;
  logic              id_branch_i, id_branch_taken_i, id_jump_i;
  logic              stall_o, flush_o;
  logic [SW-1:0]     fwd_rs_sel_o, fwd_rt_sel_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_FWD_IDX(LFI), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .hold_i(hold_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_is_load_i(id_is_load_i),
    .id_branch_i(id_branch_i), .id_branch_taken_i(id_branch_taken_i), .id_jump_i(id_jump_i),
    .stall_o(stall_o), .flush_o(flush_o), .fwd_rs_sel_o(fwd_rs_sel_o), .fwd_rt_sel_o(fwd_rt_sel_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    bit                v;
    logic [REG_AW-1:0] rd, rs, rt;
    bit                urs, urt, rw, ld, br, tk, jp;
  } id_t;

  // flight[0] is the instruction in EX, flight[DEPTH-1] the oldest still tracked.
  id_t flight[$];
  int  m_scnt, m_fcnt;
  int  n_chk, n_pass;
  int  obs_stall, obs_flush, obs_rs, obs_rt, obs_scnt, obs_fcnt;
  bit  e_stall;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic id_t nop();
    id_t x = '{default: 0};
    return x;
  endfunction

  function automatic id_t mk_alu(input int rd, input int rs, input int rt);
    id_t x = nop();
    x.v = 1; x.rw = 1; x.urs = 1; x.urt = 1;
    x.rd = REG_AW'(rd); x.rs = REG_AW'(rs); x.rt = REG_AW'(rt);
    return x;
  endfunction

  function automatic id_t mk_load(input int rd, input int rs);
    id_t x = nop();
    x.v = 1; x.rw = 1; x.ld = 1; x.urs = 1;
    x.rd = REG_AW'(rd); x.rs = REG_AW'(rs);
    return x;
  endfunction

  function automatic id_t mk_br(input int rs, input int rt, input bit taken);
    id_t x = nop();
    x.v = 1; x.br = 1; x.tk = taken; x.urs = 1; x.urt = 1;
    x.rs = REG_AW'(rs); x.rt = REG_AW'(rt);
    return x;
  endfunction

  function automatic id_t rnd();
    id_t x = nop();
    x.v   = $urandom_range(0, 99) < 85;
    x.rd  = REG_AW'($urandom_range(0, 7));
    x.rs  = REG_AW'($urandom_range(0, 7));
    x.rt  = REG_AW'($urandom_range(0, 7));
    x.urs = $urandom_range(0, 99) < 70;
    x.urt = $urandom_range(0, 99) < 70;
    x.rw  = $urandom_range(0, 99) < 70;
    x.ld  = x.rw && ($urandom_range(0, 99) < 30);
    x.br  = !x.rw && ($urandom_range(0, 99) < 40);
    x.tk  = $urandom_range(0, 1) == 1;
    x.jp  = !x.br && ($urandom_range(0, 99) < 5);
    return x;
  endfunction

  function automatic bit writes(input id_t e, input logic [REG_AW-1:0] a, input bit u);
    return e.v && e.rw && u && (a != 0) && (e.rd == a);
  endfunction

  function automatic bit reads_from(input id_t e, input id_t x);
    return writes(e, x.rs, x.urs) || writes(e, x.rt, x.urt);
  endfunction

  function automatic bit model_load_use(input id_t x);
    for (int j = 0; j < DEPTH; j++)
      if (flight[j].ld && (j + 1 < LFI) && reads_from(flight[j], x)) return 1;
    return 0;
  endfunction

  function automatic bit model_branch_haz(input id_t x);
`ifdef BRANCH_ID_RESOLVE_EN
    if (x.br)
      for (int j = 0; j < DEPTH - 1; j++)
        if (reads_from(flight[j], x)) return 1;
`endif
    return 0;
  endfunction

  function automatic int model_fwd(input bit rt_side);
    logic [REG_AW-1:0] a;
    bit u;
    if (!flight[0].v) return 0;
    a = rt_side ? flight[0].rt : flight[0].rs;
    u = rt_side ? flight[0].urt : flight[0].urs;
    for (int k = 1; k < DEPTH; k++)
      if (writes(flight[k], a, u)) return k;
    return 0;
  endfunction

  function automatic bit names_early_load(input int sel);
    return (sel != 0) && (sel < DEPTH) && (sel < LFI) && flight[sel].ld;
  endfunction

  task automatic model_reset();
    flight.delete();
    for (int i = 0; i < DEPTH; i++) flight.push_back(nop());
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  task automatic run_cycle(input id_t x, input bit h, input bit r);
    bit hz, st, fl;
    int ers, ert;
    rst_i = r; hold_i = h; id_valid_i = x.v;
    id_rs_i = x.rs; id_rt_i = x.rt; id_rd_i = x.rd;
    id_use_rs_i = x.urs; id_use_rt_i = x.urt; id_regwrite_i = x.rw; id_is_load_i = x.ld;
    id_branch_i = x.br; id_branch_taken_i = x.tk; id_jump_i = x.jp;
    @(negedge clk);
    hz  = x.v && (model_load_use(x) || model_branch_haz(x));
    st  = !r && (hz || h);
    fl  = !r && x.v && !st && (x.jp || (x.br && x.tk));
    ers = r ? 0 : model_fwd(0);
    ert = r ? 0 : model_fwd(1);
    obs_stall = int'(stall_o); obs_flush = int'(flush_o);
    obs_rs = int'(fwd_rs_sel_o); obs_rt = int'(fwd_rt_sel_o);
    obs_scnt = int'(stall_cnt_o); obs_fcnt = int'(flush_cnt_o);
    chk("stall", obs_stall, int'(st));
    chk("flush", obs_flush, int'(fl));
    chk("fwd_rs", obs_rs, ers);
    chk("fwd_rt", obs_rt, ert);
    chk("stall_cnt", obs_scnt, m_scnt);
    chk("flush_cnt", obs_fcnt, m_fcnt);
    if (!r) begin
      chk("inv_rs_load", int'(names_early_load(obs_rs)), 0);
      chk("inv_rt_load", int'(names_early_load(obs_rt)), 0);
    end
    e_stall = st;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (!h) begin
      if (hz && m_scnt < CNT_MAX) m_scnt++;
      if (fl && m_fcnt < CNT_MAX) m_fcnt++;
      flight.push_front(st ? nop() : x);
      void'(flight.pop_back());
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    id_t x;
    int saved_scnt, saved_fcnt;
    n_chk = 0; n_pass = 0;
    model_reset();
    x = nop();
    rst_i = 1; hold_i = 0; id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; id_rd_i = 0;
    id_use_rs_i = 0; id_use_rt_i = 0; id_regwrite_i = 0; id_is_load_i = 0;
    id_branch_i = 0; id_branch_taken_i = 0; id_jump_i = 0;
    repeat (2) @(posedge clk);
    #1;
    run_cycle(nop(), 0, 1);

    // Load-use: lw $2 ; add $3,$2,$4
    run_cycle(mk_load(2, 1), 0, 0);
    run_cycle(mk_alu(3, 2, 4), 0, 0);
    chk("t1_stall_on", obs_stall, 1);
    run_cycle(mk_alu(3, 2, 4), 0, 0);
    chk("t1_stall_off", obs_stall, 0);
    run_cycle(nop(), 0, 0);
    chk("t1_fwd_rs", obs_rs, 2);
    chk("t1_stall_cnt", obs_scnt, 1);

    // Youngest writer wins
    run_cycle(mk_alu(5, 1, 1), 0, 0);
    run_cycle(mk_alu(5, 1, 1), 0, 0);
    run_cycle(mk_alu(6, 5, 0), 0, 0);
    run_cycle(nop(), 0, 0);
    chk("t2_fwd_rs", obs_rs, 1);

    // Register 0 never matches
    run_cycle(mk_load(0, 1), 0, 0);
    run_cycle(mk_alu(6, 0, 0), 0, 0);
    chk("t3_no_stall", obs_stall, 0);
    run_cycle(nop(), 0, 0);
    chk("t3_fwd_rs", obs_rs, 0);
    chk("t3_fwd_rt", obs_rt, 0);

    // Taken branch behind a load-use hazard: stall first, flush once resolved
    run_cycle(nop(), 0, 1);
    run_cycle(mk_load(2, 1), 0, 0);
    run_cycle(mk_br(2, 0, 1), 0, 0);
    chk("t4_stall", obs_stall, 1);
    chk("t4_no_flush", obs_flush, 0);
    for (int i = 0; i < 8; i++) begin
      run_cycle(mk_br(2, 0, 1), 0, 0);
      if (obs_stall == 0) break;
    end
    chk("t4_flush", obs_flush, 1);
    run_cycle(nop(), 0, 0);
    chk("t4_flush_cnt", obs_fcnt, 1);

    // Hold freezes tracker and counters
    run_cycle(mk_alu(1, 2, 3), 0, 0);
    run_cycle(mk_alu(2, 1, 1), 0, 0);
    saved_scnt = m_scnt;
    saved_fcnt = m_fcnt;
    for (int i = 0; i < 5; i++) begin
      run_cycle(mk_load(4, 2), 1, 0);
      chk("t5_hold_stall", obs_stall, 1);
      chk("t5_hold_flush", obs_flush, 0);
      chk("t5_hold_rs", obs_rs, 1);
      chk("t5_hold_rt", obs_rt, 1);
      chk("t5_hold_scnt", obs_scnt, saved_scnt);
      chk("t5_hold_fcnt", obs_fcnt, saved_fcnt);
    end
    run_cycle(nop(), 0, 0);
    chk("t5_after_rs", obs_rs, 1);

    // Saturation: six load-use stalls on a 2-bit counter
    run_cycle(nop(), 0, 1);
    for (int i = 0; i < 6; i++) begin
      run_cycle(mk_load(2, 1), 0, 0);
      run_cycle(mk_alu(3, 2, 4), 0, 0);
      run_cycle(mk_alu(3, 2, 4), 0, 0);
    end
    run_cycle(nop(), 0, 0);
    chk("sat_stall_cnt", obs_scnt, 3);

    // Reset with a full tracker
    run_cycle(mk_alu(1, 0, 0), 0, 0);
    run_cycle(mk_alu(2, 1, 1), 0, 0);
    run_cycle(mk_alu(3, 2, 2), 0, 0);
    run_cycle(mk_alu(4, 3, 3), 1, 1);
    chk("t6_rst_stall", obs_stall, 0);
    run_cycle(mk_alu(4, 3, 3), 0, 0);
    chk("t6_rs", obs_rs, 0);
    chk("t6_rt", obs_rt, 0);
    chk("t6_stall", obs_stall, 0);
    chk("t6_scnt", obs_scnt, 0);
    chk("t6_fcnt", obs_fcnt, 0);

`ifdef BRANCH_ID_RESOLVE_EN
    run_cycle(mk_alu(7, 1, 1), 0, 0);
    run_cycle(mk_br(7, 0, 0), 0, 0);
    chk("br_id_stall", obs_stall, 1);
    for (int i = 0; i < 8; i++) begin
      run_cycle(mk_br(7, 0, 0), 0, 0);
      if (obs_stall == 0) break;
    end
    chk("br_id_release", obs_stall, 0);
`endif

    // Random traffic; a stalled ID instruction usually stays put like a real pipe
    run_cycle(nop(), 0, 1);
    x = rnd();
    for (int i = 0; i < 3000; i++) begin
      if (!(e_stall && ($urandom_range(0, 99) < 80))) x = rnd();
      run_cycle(x, $urandom_range(0, 99) < 8, $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
